// File: rtl/mem_dirty_flush_ctrl.sv
// ---------------------------------------------------------------------------
// mem_dirty_flush_ctrl
//
// Purpose:
//   Scans the data-memory dirty-bit tracker from address 0 up to
//   N_ELEMENTS-1 and streams every dirty word (address + data) to the
//   debug-unit TX path. The debug unit starts a scan at end of program and
//   routes o_addr / o_mem_re onto the memory port while o_busy is high.
//
// Ports:
//   i_clock      system clock, all state updates on posedge
//   i_reset      synchronous active-low reset (0 = reset)
//   i_start      start a scan (sampled only in IDLE)
//   i_abort      end the scan early (sampled in CHECK/READ/WAIT/SEND/NEXT)
//   i_dirty_bit  tracker bit for o_addr (combinational from o_addr)
//   i_mem_data   memory read data, valid one cycle after o_mem_re
//   i_tx_ready   TX sink can accept a word
//   o_addr       scan address to tracker and memory
//   o_mem_re     memory read enable (READ state only)
//   o_tx_valid   o_tx_addr / o_tx_data valid (SEND state only)
//   o_tx_addr    address of the word being transferred
//   o_tx_data    data of the word being transferred
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse at end of scan (normal or aborted)
//   o_count      dirty words transferred in the current / last scan
// ---------------------------------------------------------------------------
module mem_dirty_flush_ctrl #(
  parameter int N_ELEMENTS = 128,
  parameter int ADDR_W     = $clog2(N_ELEMENTS),
  parameter int DATA_W     = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_dirty_bit,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_tx_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_mem_re,
  output logic              o_tx_valid,
  output logic [ADDR_W-1:0] o_tx_addr,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WAIT,
    S_SEND,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEMENTS - 1);

  state_t state;
  state_t state_nxt;
  logic   handshake;

  // A word is consumed when the sink is ready while SEND presents it.
  assign handshake = (state == S_SEND) && i_tx_ready;

  // State register.
  // NOTE: the reset term sits inside the clocked block, so it is synchronous;
  // sequential state always uses non-blocking assignments.
  always_ff @(posedge i_clock) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (i_start) state_nxt = S_CHECK;
      S_CHECK: state_nxt = i_dirty_bit ? S_READ : S_NEXT;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_SEND;
      S_SEND:  if (handshake) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (o_addr == LAST_ADDR) ? S_DONE : S_CHECK;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides the normal flow in every busy state but DONE.
    if (i_abort && (state != S_IDLE) && (state != S_DONE)) state_nxt = S_DONE;
  end

  // Datapath registers: scan address, captured word, transfer counter.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_addr    <= '0;
      o_tx_addr <= '0;
      o_tx_data <= '0;
      o_count   <= '0;
    end else begin
      if (state == S_IDLE && i_start) begin
        o_addr  <= '0;
        o_count <= '0;
      end
      // The address only advances when the scan really continues, so an
      // abort seen in NEXT leaves o_addr on the last address looked at.
      if (state == S_NEXT && state_nxt == S_CHECK) o_addr <= o_addr + ADDR_W'(1);
      if (state == S_WAIT) begin
        o_tx_addr <= o_addr;
        o_tx_data <= i_mem_data;
      end
      // Counts even when abort arrives in the same cycle as the handshake.
      if (handshake) o_count <= o_count + (ADDR_W + 1)'(1);
    end
  end

  // Outputs that are a pure decode of the state register.
  always_comb begin
    o_mem_re   = (state == S_READ);
    o_tx_valid = (state == S_SEND);
    o_busy     = (state != S_IDLE);
    o_done     = (state == S_DONE);
  end

endmodule

// File: tb/tb_mem_dirty_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_dirty_flush_ctrl
//
// Directed bench for mem_dirty_flush_ctrl. A small memory / tracker model
// answers the DUT; expected transfers are queued when a scenario is set up
// and a negedge monitor pops and compares them on every handshake.
// ---------------------------------------------------------------------------
module tb_mem_dirty_flush_ctrl;

  localparam int N_ELEMENTS = 128;
  localparam int ADDR_W     = $clog2(N_ELEMENTS);
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } xfer_t;

  logic              clk;
  logic              i_reset;
  logic              i_start;
  logic              i_abort;
  logic              i_dirty_bit;
  logic [DATA_W-1:0] i_mem_data;
  logic              i_tx_ready;
  logic [ADDR_W-1:0] o_addr;
  logic              o_mem_re;
  logic              o_tx_valid;
  logic [ADDR_W-1:0] o_tx_addr;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W:0]   o_count;

  logic [N_ELEMENTS-1:0] dirty;
  xfer_t                 exp_q[$];
  int                    errors = 0;
  int                    checks = 0;
  int                    re_cycles = 0;
  int                    valid_cycles = 0;

  mem_dirty_flush_ctrl #(
    .N_ELEMENTS(N_ELEMENTS),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_dirty_bit(i_dirty_bit),
    .i_mem_data (i_mem_data),
    .i_tx_ready (i_tx_ready),
    .o_addr     (o_addr),
    .o_mem_re   (o_mem_re),
    .o_tx_valid (o_tx_valid),
    .o_tx_addr  (o_tx_addr),
    .o_tx_data  (o_tx_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_count    (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tracker model: combinational lookup of the scan address.
  assign i_dirty_bit = dirty[o_addr];

  // Memory model: word a holds 0xA0 + a, one-cycle read latency.
  always @(posedge clk) begin
    if (o_mem_re) i_mem_data <= 32'hA0 + 32'(o_addr);
  end

  function automatic logic [DATA_W-1:0] mem_word(input int a);
    return 32'hA0 + 32'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handshake happens at the coming posedge whenever
  // valid and ready are both high at the negedge.
  always @(negedge clk) begin
    if (o_mem_re)   re_cycles++;
    if (o_tx_valid) valid_cycles++;
    if (i_reset && o_tx_valid && i_tx_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_xfer", {57'd0, o_tx_addr}, 64'hFFFF);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        check("sb_tx_addr", 64'(o_tx_addr), 64'(e.addr));
        check("sb_tx_data", 64'(o_tx_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Cycles counted from the first CHECK cycle up to the o_done cycle.
  task automatic run_to_done(output int cyc, output int wraps);
    logic [ADDR_W-1:0] prev;
    cyc   = 0;
    wraps = 0;
    prev  = o_addr;
    while (!o_done && cyc < 2000) begin
      if (o_addr < prev) wraps++;
      prev = o_addr;
      tick();
      cyc++;
    end
    check("done_reached", 64'(o_done), 64'd1);
  endtask

  task automatic wait_send(input logic [ADDR_W-1:0] addr);
    int n = 0;
    while (!(o_tx_valid && o_tx_addr == addr) && n < 2000) begin
      tick();
      n++;
    end
    check("send_reached", 64'(o_tx_valid && o_tx_addr == addr), 64'd1);
  endtask

  task automatic finish_idle(input string tag, input int count);
    tick();
    check({tag, "_done_pulse_once"}, 64'(o_done), 64'd0);
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
    check({tag, "_count"}, 64'(o_count), 64'(count));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back('{addr: ADDR_W'(a), data: mem_word(a)});
  endtask

  initial begin
    int cyc;
    int wraps;
    int re0;
    int v0;

    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_tx_ready = 1'b1;
    dirty      = '0;
    tick();
    tick();
    check("rst_busy",  64'(o_busy),     64'd0);
    check("rst_addr",  64'(o_addr),     64'd0);
    check("rst_count", 64'(o_count),   64'd0);
    check("rst_valid", 64'(o_tx_valid), 64'd0);
    check("rst_txd",   64'(o_tx_data),  64'd0);
    i_reset = 1'b1;
    tick();

    // 1: words 0..5 dirty, sink always ready.
    dirty = 128'h3F;
    push_range(0, 5);
    re0 = re_cycles;
    do_start();
    check("t1_busy", 64'(o_busy), 64'd1);
    run_to_done(cyc, wraps);
    check("t1_cycles", 64'(cyc), 64'd274);
    check("t1_re_cycles", 64'(re_cycles - re0), 64'd6);
    finish_idle("t1", 6);

    // 2: all clean.
    dirty = '0;
    re0 = re_cycles;
    v0  = valid_cycles;
    do_start();
    run_to_done(cyc, wraps);
    check("t2_cycles", 64'(cyc), 64'd256);
    check("t2_no_re", 64'(re_cycles - re0), 64'd0);
    check("t2_no_valid", 64'(valid_cycles - v0), 64'd0);
    finish_idle("t2", 0);

    // 3: word 3 dirty, sink stalls for 10 cycles.
    dirty      = 128'h8;
    i_tx_ready = 1'b0;
    do_start();
    wait_send(ADDR_W'(3));
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", 64'(o_tx_valid), 64'd1);
      check("t3_hold_addr",  64'(o_tx_addr),  64'd3);
      check("t3_hold_data",  64'(o_tx_data),  64'hA3);
      check("t3_hold_count", 64'(o_count),    64'd0);
      tick();
    end
    push_range(3, 3);
    i_tx_ready = 1'b1;
    tick();
    check("t3_count_after", 64'(o_count), 64'd1);
    run_to_done(cyc, wraps);
    finish_idle("t3", 1);

    // 4: only the last word dirty; the address must stop at 127.
    dirty = '0;
    dirty[N_ELEMENTS-1] = 1'b1;
    push_range(127, 127);
    do_start();
    run_to_done(cyc, wraps);
    check("t4_no_wrap", 64'(wraps), 64'd0);
    check("t4_last_addr", 64'(o_addr), 64'd127);
    finish_idle("t4", 1);

    // 5a: abort while SEND of word 2 stalls; word 0 already counted.
    dirty = 128'h5;
    push_range(0, 0);
    i_tx_ready = 1'b1;
    do_start();
    begin
      int n = 0;
      while (o_addr != 1 && n < 100) begin
        tick();
        n++;
      end
    end
    i_tx_ready = 1'b0;
    wait_send(ADDR_W'(2));
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("t5a_done", 64'(o_done), 64'd1);
    check("t5a_valid_drop", 64'(o_tx_valid), 64'd0);
    check("t5a_count", 64'(o_count), 64'd1);
    finish_idle("t5a", 1);

    // 5b: abort together with the handshake; the word counts.
    dirty = 128'h4;
    do_start();
    wait_send(ADDR_W'(2));
    push_range(2, 2);
    i_tx_ready = 1'b1;
    i_abort    = 1'b1;
    tick();
    i_abort = 1'b0;
    check("t5b_done", 64'(o_done), 64'd1);
    check("t5b_count", 64'(o_count), 64'd1);
    finish_idle("t5b", 1);

    // 6: reset during WAIT, then a full rescan.
    dirty = 128'h3F;
    do_start();
    begin
      int n = 0;
      while (!o_mem_re && n < 100) begin
        tick();
        n++;
      end
      check("t6_read_seen", 64'(o_mem_re), 64'd1);
    end
    tick();
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    check("t6_rst_busy",  64'(o_busy),     64'd0);
    check("t6_rst_addr",  64'(o_addr),     64'd0);
    check("t6_rst_txa",   64'(o_tx_addr),  64'd0);
    check("t6_rst_txd",   64'(o_tx_data),  64'd0);
    check("t6_rst_count", 64'(o_count),    64'd0);
    check("t6_rst_re",    64'(o_mem_re),   64'd0);
    push_range(0, 5);
    do_start();
    check("t6_restart_addr", 64'(o_addr), 64'd0);
    run_to_done(cyc, wraps);
    check("t6_cycles", 64'(cyc), 64'd274);
    finish_idle("t6", 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
